adat_rx_stream_out: RTL and testbench

Downstream stage of adat_rx_adat_rx. Captures each decoded 8-channel ADAT frame (o_channels/o_user on the o_valid pulse) into a small frame FIFO. Replays each frame as a ready/valid sample stream, one 24-bit word per beat, channel 0..7, with a last-flag on channel 7. Decouples the receiver's fixed frame timing from a back-pressured consumer such as a DSP block or an I2S/TDM serializer.

---
 rtl/adat_rx_adat_pkg.sv | 19 +
 rtl/adat_rx_frame_fifo.sv | 63 ++++++
 rtl/adat_rx_stream_out.sv | 152 +++++++++++++++
 tb/tb_adat_rx_stream_out.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adat_rx_adat_pkg.sv
// Shared types and constants for the ADAT receive path: the frame record
// carried between the receiver and the stream output stage.
package adat_rx_adat_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int SAMPLE_WIDTH = 24;
  localparam logic [2:0] LAST_CHAN = 3'(NUM_CHANNELS - 1);

  typedef struct packed {
    logic [3:0]                                     user;
    logic [0:NUM_CHANNELS-1][SAMPLE_WIDTH-1:0]      samples;
  } AdatFrame;

  typedef enum logic {
    IDLE,
    SEND
  } StreamState;

endpackage

// File: rtl/adat_rx_frame_fifo.sv
// Frame FIFO for decoded ADAT frames; exposes the head and the entry behind it
// so the stream stage can start the next frame without an idle cycle.
module adat_rx_frame_fifo
  import adat_rx_adat_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  AdatFrame           wr_data,
  output AdatFrame           head,
  output AdatFrame           next,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEVEL_W-1:0] PTR_ONE = LEVEL_W'(1);

  AdatFrame           mem [DEPTH];
  logic [LEVEL_W-1:0] wr_ptr;
  logic [LEVEL_W-1:0] rd_ptr;
  logic [LEVEL_W-1:0] rd_next;
  logic               do_write;
  logic               do_pop;

  assign rd_next  = rd_ptr + PTR_ONE;
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot being written, so full need not block it.
  assign do_write = push && (!full || do_pop);

  assign head = mem[rd_ptr[AW-1:0]];
  assign next = mem[rd_next[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= rd_next;
      // Flush keeps only the head entry; everything queued behind it is discarded.
      if (flush)
        wr_ptr <= empty ? rd_ptr : rd_next;
      else if (do_write)
        wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/adat_rx_stream_out.sv
// Buffers decoded ADAT frames and replays them as a ready/valid sample stream.
// Optional statistics (drop counter, level high-watermark): ADAT_RX_STREAM_STATS_EN.
module adat_rx_stream_out
  import adat_rx_adat_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [0:7][23:0]   i_channels,
  input  logic [3:0]         i_user,
  input  logic               i_valid,
  input  logic               i_locked,
  output logic [23:0]        o_tdata,
  output logic [2:0]         o_tchan,
  output logic [3:0]         o_tuser,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               i_tready,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_overflow,
  output logic [15:0]        o_drop_count,
  output logic [LEVEL_W-1:0] o_max_level
);

  StreamState         state;
  StreamState         next_state;
  AdatFrame           push_frame;
  AdatFrame           fifo_head;
  AdatFrame           fifo_next;
  AdatFrame           load_frame;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               push;
  logic               pop;
  logic               flush;
  logic               drop;
  logic               beat;
  logic               load_head;
  logic               load_next;
  logic [2:0]         next_chan;

  assign push_frame = {i_user, i_channels};
  assign push       = i_valid && i_locked;
  assign flush      = !i_locked;
  assign beat       = o_tvalid && i_tready;
  assign drop       = push && fifo_full && !pop;
  assign next_chan  = o_tchan + 3'd1;
  assign load_frame = load_next ? fifo_next : fifo_head;
  assign o_level    = fifo_level - LEVEL_W'(state == SEND);

  adat_rx_frame_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (push_frame),
    .head    (fifo_head),
    .next    (fifo_next),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_head  = 1'b0;
    load_next  = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && i_locked) begin
          load_head  = 1'b1;
          next_state = SEND;
        end else if (!fifo_empty) begin
          // A frame left waiting when lock drops is stale; discard it too.
          pop = 1'b1;
        end
      end
      SEND: begin
        if (beat && (o_tchan == LAST_CHAN)) begin
          pop = 1'b1;
          if (i_locked && (fifo_level > LEVEL_W'(1)))
            load_next = 1'b1;
          else
            next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_tdata    <= '0;
      o_tchan    <= '0;
      o_tuser    <= '0;
      o_tlast    <= 1'b0;
      o_tvalid   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= drop;
      if (load_head || load_next) begin
        o_tdata  <= load_frame.samples[0];
        o_tchan  <= '0;
        o_tuser  <= load_frame.user;
        o_tlast  <= 1'b0;
        o_tvalid <= 1'b1;
      end else if (beat) begin
        if (o_tchan == LAST_CHAN) begin
          o_tvalid <= 1'b0;
          o_tlast  <= 1'b0;
        end else begin
          o_tchan <= next_chan;
          o_tdata <= fifo_head.samples[next_chan];
          o_tlast <= (next_chan == LAST_CHAN);
        end
      end
    end
  end

`ifdef ADAT_RX_STREAM_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_drop_count <= '0;
      o_max_level  <= '0;
    end else begin
      if (drop && (o_drop_count != 16'hFFFF))
        o_drop_count <= o_drop_count + 16'd1;
      if (o_level > o_max_level)
        o_max_level <= o_level;
    end
  end
`else
  assign o_drop_count = '0;
  assign o_max_level  = '0;
`endif

endmodule

// File: tb/tb_adat_rx_stream_out.sv
// Self-checking bench for adat_rx_stream_out: reference frames are expanded
// into the expected beat sequence and compared against the captured stream.
module tb_adat_rx_stream_out;

  logic             clk;
  logic             i_rst;
  logic [0:7][23:0] i_channels;
  logic [3:0]       i_user;
  logic             i_valid;
  logic             i_locked;
  logic [23:0]      o_tdata;
  logic [2:0]       o_tchan;
  logic [3:0]       o_tuser;
  logic             o_tlast;
  logic             o_tvalid;
  logic             i_tready;
  logic [2:0]       o_level;
  logic             o_overflow;
  logic [15:0]      o_drop_count;
  logic [2:0]       o_max_level;

  adat_rx_stream_out #(.FIFO_DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_channels   (i_channels),
    .i_user       (i_user),
    .i_valid      (i_valid),
    .i_locked     (i_locked),
    .o_tdata      (o_tdata),
    .o_tchan      (o_tchan),
    .o_tuser      (o_tuser),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .i_tready     (i_tready),
    .o_level      (o_level),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count),
    .o_max_level  (o_max_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        tready;
    logic        exp_tvalid;
    logic [2:0]  exp_tchan;
    logic [23:0] exp_tdata;
    logic        exp_tlast;
    logic [3:0]  exp_tuser;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t             tbl [10];
  logic [23:0]      spec_data [8];
  logic [0:7][23:0] frm_ch [16];
  logic [3:0]       frm_u [16];
  logic [31:0]      beat_q [$];
  logic [31:0]      exp_q [$];
  logic [31:0]      held;
  logic             was_stall;
  int               total;
  int               bad;
  int               last_cnt;
  int               ovf_cnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic locked, input logic tready, input int fidx);
    i_valid    = valid;
    i_locked   = locked;
    i_tready   = tready;
    i_channels = frm_ch[fidx];
    i_user     = frm_u[fidx];
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Capture completed beats, check AXI-stream hold rule, count overflow cycles.
  always @(negedge clk) begin
    if (!i_rst) begin
      was_stall <= 1'b0;
    end else begin
      if (was_stall) begin
        checkOutput("stall_tvalid", 64'(o_tvalid), 64'd1);
        checkOutput("stall_hold", {32'd0, o_tuser, o_tlast, o_tchan, o_tdata}, {32'd0, held});
      end
      if (o_tvalid && i_tready) begin
        beat_q.push_back({o_tuser, o_tlast, o_tchan, o_tdata});
        if (o_tlast)
          last_cnt++;
      end
      if (o_overflow)
        ovf_cnt++;
      was_stall <= o_tvalid && !i_tready;
      held      <= {o_tuser, o_tlast, o_tchan, o_tdata};
    end
  end

  task automatic clearMon();
    beat_q.delete();
    exp_q.delete();
    last_cnt = 0;
    ovf_cnt  = 0;
  endtask

  task automatic addExpected(input int f);
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      cc = c[2:0];
      exp_q.push_back({frm_u[f], (cc == 3'd7), cc, frm_ch[f][cc]});
    end
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, "_beat_count"}, 64'(beat_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]), 64'(exp_q[i]));
  endtask

  task automatic waitLast(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (last_cnt < target && n < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 0);
      n++;
    end
    checkOutput({tag, "_drain"}, 64'(last_cnt), 64'(target));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int pushed;
    logic v;

    clk = 0; i_rst = 0; i_valid = 0; i_locked = 1; i_tready = 0;
    i_channels = '0; i_user = '0;
    total = 0; bad = 0; was_stall = 0; held = '0;
    clearMon();

    spec_data = '{24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678,
                  24'h9ABCDE, 24'hF01234, 24'h567890, 24'hABCDEF};
    for (int c = 0; c < 8; c++) frm_ch[0][c] = spec_data[c];
    frm_u[0] = 4'hA;
    for (int f = 1; f < 16; f++) begin
      for (int c = 0; c < 8; c++) frm_ch[f][c] = 24'($urandom);
      frm_u[f] = 4'($urandom);
    end

    tbl[0] = '{valid: 1'b1, tready: 1'b1, exp_tvalid: 1'b0, exp_tchan: 3'd0,
               exp_tdata: 24'd0, exp_tlast: 1'b0, exp_tuser: 4'd0, exp_level: 3'd1};
    for (int r = 1; r <= 8; r++)
      tbl[r] = '{valid: 1'b0, tready: 1'b1, exp_tvalid: 1'b1, exp_tchan: 3'(r - 1),
                 exp_tdata: spec_data[r - 1], exp_tlast: (r == 8), exp_tuser: 4'hA, exp_level: 3'd0};
    tbl[9] = '{valid: 1'b0, tready: 1'b1, exp_tvalid: 1'b0, exp_tchan: 3'd0,
               exp_tdata: 24'd0, exp_tlast: 1'b0, exp_tuser: 4'd0, exp_level: 3'd0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(o_tdata), 64'd0);
    checkOutput("rst_tchan", 64'(o_tchan), 64'd0);
    checkOutput("rst_tuser", 64'(o_tuser), 64'd0);
    checkOutput("rst_tlast", 64'(o_tlast), 64'd0);
    checkOutput("rst_level", 64'(o_level), 64'd0);
    checkOutput("rst_overflow", 64'(o_overflow), 64'd0);
    checkOutput("rst_drop_count", 64'(o_drop_count), 64'd0);
    checkOutput("rst_max_level", 64'(o_max_level), 64'd0);
    i_rst = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0);

    $display("[TB] single frame table");
    clearMon();
    for (int r = 0; r < 10; r++) begin
      applyStimulus(tbl[r].valid, 1'b1, tbl[r].tready, 0);
      checkOutput($sformatf("tbl%0d_tvalid", r), 64'(o_tvalid), 64'(tbl[r].exp_tvalid));
      checkOutput($sformatf("tbl%0d_level", r), 64'(o_level), 64'(tbl[r].exp_level));
      if (tbl[r].exp_tvalid) begin
        checkOutput($sformatf("tbl%0d_tchan", r), 64'(o_tchan), 64'(tbl[r].exp_tchan));
        checkOutput($sformatf("tbl%0d_tdata", r), 64'(o_tdata), 64'(tbl[r].exp_tdata));
        checkOutput($sformatf("tbl%0d_tlast", r), 64'(o_tlast), 64'(tbl[r].exp_tlast));
        checkOutput($sformatf("tbl%0d_tuser", r), 64'(o_tuser), 64'(tbl[r].exp_tuser));
      end
    end
    addExpected(0);
    compareStream("single");

    $display("[TB] random back-pressure");
    clearMon();
    pushed = 0;
    n = 0;
    while (last_cnt < 10 && n < 3000) begin
      v = (pushed < 10) && ((pushed - last_cnt) < 3) && ($urandom_range(0, 1) == 1);
      applyStimulus(v, 1'b1, ($urandom_range(0, 99) < 30), pushed + 1);
      if (v) begin
        addExpected(pushed + 1);
        pushed++;
      end
      n++;
    end
    checkOutput("bp_drain", 64'(last_cnt), 64'd10);
    compareStream("bp");
    checkOutput("bp_overflow", 64'(ovf_cnt), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0);

    $display("[TB] overflow");
    clearMon();
    for (int f = 1; f <= 6; f++) applyStimulus(1'b1, 1'b1, 1'b0, f);
    for (int f = 1; f <= 4; f++) addExpected(f);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("ovf_level", 64'(o_level), 64'd3);
    checkOutput("ovf_pulses", 64'(ovf_cnt), 64'd2);
    checkOutput("ovf_tvalid", 64'(o_tvalid), 64'd1);
    checkOutput("ovf_tchan", 64'(o_tchan), 64'd0);
`ifdef ADAT_RX_STREAM_STATS_EN
    checkOutput("ovf_drop_count", 64'(o_drop_count), 64'd2);
    checkOutput("ovf_max_level", 64'(o_max_level), 64'd3);
`else
    checkOutput("ovf_drop_count", 64'(o_drop_count), 64'd0);
    checkOutput("ovf_max_level", 64'(o_max_level), 64'd0);
`endif
    waitLast(4, 200, "ovf");
    compareStream("ovf");
    checkOutput("ovf_end_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("ovf_end_level", 64'(o_level), 64'd0);

    $display("[TB] push/pop collision");
    clearMon();
    for (int f = 1; f <= 4; f++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, f);
      addExpected(f);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("coll_level_full", 64'(o_level), 64'd3);
    n = 0;
    while (!(o_tvalid && o_tchan == 3'd7) && n < 50) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 0);
      n++;
    end
    checkOutput("coll_reach_ch7", 64'(o_tchan), 64'd7);
    applyStimulus(1'b1, 1'b1, 1'b1, 5);
    addExpected(5);
    checkOutput("coll_level", 64'(o_level), 64'd3);
    checkOutput("coll_b2b_tvalid", 64'(o_tvalid), 64'd1);
    checkOutput("coll_b2b_tdata", 64'(o_tdata), 64'(frm_ch[2][0]));
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    checkOutput("coll_overflow", 64'(ovf_cnt), 64'd0);
    waitLast(5, 300, "coll");
    compareStream("coll");

    $display("[TB] lock loss");
    clearMon();
    for (int f = 1; f <= 4; f++) applyStimulus(1'b1, 1'b1, 1'b0, f);
    addExpected(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("lock_level_queued", 64'(o_level), 64'd3);
    n = 0;
    while (!(o_tvalid && o_tchan == 3'd3) && n < 50) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 0);
      n++;
    end
    checkOutput("lock_reach_ch3", 64'(o_tchan), 64'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 5);
    checkOutput("lock_flush_level", 64'(o_level), 64'd0);
    checkOutput("lock_inflight_tchan", 64'(o_tchan), 64'd4);
    for (int k = 0; k < 12; k++) applyStimulus(k[0], 1'b0, 1'b1, 6);
    checkOutput("lock_end_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("lock_end_level", 64'(o_level), 64'd0);
    compareStream("lock");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
    checkOutput("relock_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("relock_level", 64'(o_level), 64'd0);

    $display("[TB] async reset mid-frame");
    clearMon();
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("pre_rst_tvalid", 64'(o_tvalid), 64'd1);
    checkOutput("pre_rst_level", 64'(o_level), 64'd1);
    #2;
    i_rst = 0;
    #1;
    checkOutput("async_rst_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("async_rst_level", 64'(o_level), 64'd0);
    @(posedge clk);
    #1;
    i_rst = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    checkOutput("post_rst_idle", 64'(o_tvalid), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    addExpected(3);
    waitLast(1, 50, "post_rst");
    compareStream("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
